// File: rtl/mult_ctrl_if.sv
// rtl/mult_ctrl_if.sv - host handshake and adder-side signal bundle for mult_ctrl
interface mult_ctrl_if;
    logic        start;
    logic [7:0]  multiplier;
    logic [7:0]  multiplicand_in;
    logic        busy;
    logic        done;
    logic [15:0] product;
    logic [7:0]  add_a;
    logic [7:0]  add_b;
    logic        add_clr;
    logic [7:0]  add_sum;

    modport master (
        output start, multiplier, multiplicand_in, add_sum,
        input  busy, done, product, add_a, add_b, add_clr
    );

    modport slave (
        input  start, multiplier, multiplicand_in, add_sum,
        output busy, done, product, add_a, add_b, add_clr
    );
endinterface

// File: rtl/mult_ctrl.sv
// rtl/mult_ctrl.sv - 8x8 shift-and-add multiplier sequencer driving a registered adder
// Optional: MULT_CTRL_ZERO_SKIP_EN bypasses the adder for zero multiplier bits.
module mult_ctrl #(
    parameter int ADD_LAT = 8
) (
    input  logic         clk,
    input  logic         res,
    mult_ctrl_if.slave   bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_EVAL  = 3'd1;
    localparam logic [2:0] S_ADD   = 3'd2;
    localparam logic [2:0] S_SHIFT = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [3:0] WAIT_INIT = 4'(ADD_LAT - 1);

    logic [2:0]  state;
    logic [7:0]  acc_hi;
    logic [7:0]  acc_lo;
    logic [7:0]  mcand;
    logic [2:0]  bitcnt;
    logic [3:0]  wait_cnt;
    logic        cy;
    logic [15:0] product_r;

    always_ff @(posedge clk) begin
        if (res) begin
            state     <= S_IDLE;
            acc_hi    <= 8'd0;
            acc_lo    <= 8'd0;
            mcand     <= 8'd0;
            bitcnt    <= 3'd0;
            wait_cnt  <= 4'd0;
            cy        <= 1'b0;
            product_r <= 16'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        acc_hi <= 8'd0;
                        acc_lo <= bus.multiplier;
                        mcand  <= bus.multiplicand_in;
                        bitcnt <= 3'd0;
                        cy     <= 1'b0;
                        state  <= S_EVAL;
                    end
                end
                S_EVAL: begin
`ifdef MULT_CTRL_ZERO_SKIP_EN
                    if (!acc_lo[0]) begin
                        cy    <= 1'b0;
                        state <= S_SHIFT;
                    end else begin
                        wait_cnt <= WAIT_INIT;
                        state    <= S_ADD;
                    end
`else
                    wait_cnt <= WAIT_INIT;
                    state    <= S_ADD;
`endif
                end
                S_ADD: begin
                    // The adder has no carry-out: a wrapped sum is smaller than its addend.
                    if (wait_cnt == 4'd0) begin
                        acc_hi <= bus.add_sum;
                        cy     <= (bus.add_sum < bus.add_a);
                        state  <= S_SHIFT;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                S_SHIFT: begin
                    {acc_hi, acc_lo} <= {cy, acc_hi, acc_lo[7:1]};
                    cy <= 1'b0;
                    if (bitcnt == 3'd7) begin
                        product_r <= {cy, acc_hi, acc_lo[7:1]};
                        state     <= S_DONE;
                    end else begin
                        bitcnt <= bitcnt + 3'd1;
                        state  <= S_EVAL;
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy    = (state != S_IDLE);
    assign bus.done    = (state == S_DONE);
    assign bus.product = product_r;
    assign bus.add_a   = acc_hi;
    assign bus.add_b   = (state == S_ADD && acc_lo[0]) ? mcand : 8'd0;
`ifdef MULT_CTRL_ZERO_SKIP_EN
    assign bus.add_clr = res | (state == S_EVAL && acc_lo[0]);
`else
    assign bus.add_clr = res | (state == S_EVAL);
`endif
endmodule

// File: tb/tb_mult_ctrl.sv
// tb/tb_mult_ctrl.sv - directed-vector bench for mult_ctrl with ideal adder models
module tb_mult_ctrl;
    logic clk = 1'b0;
    logic res;
    logic res_m;
    logic [7:0] add_q;

    int vectors = 0;
    int errors  = 0;

`ifdef MULT_CTRL_ZERO_SKIP_EN
    localparam int LAT_13   = 41;
    localparam int LAT_255  = 81;
    localparam int LAT_0    = 17;
    localparam int LAT_5    = 33;
    localparam int LAT_7    = 41;
    localparam int LAT_MIN  = 18;
    localparam int CLR_13   = 3;
    localparam int CLR_0    = 0;
`else
    localparam int LAT_13   = 81;
    localparam int LAT_255  = 81;
    localparam int LAT_0    = 81;
    localparam int LAT_5    = 81;
    localparam int LAT_7    = 81;
    localparam int LAT_MIN  = 25;
    localparam int CLR_13   = 8;
    localparam int CLR_0    = 8;
`endif

    always #5 clk = ~clk;

    mult_ctrl_if bus ();
    mult_ctrl_if bus_m ();

    mult_ctrl #(.ADD_LAT(8)) u_dut (
        .clk (clk),
        .res (res),
        .bus (bus)
    );

    mult_ctrl #(.ADD_LAT(1)) u_dut_min (
        .clk (clk),
        .res (res_m),
        .bus (bus_m)
    );

    // Registered adder: clear on add_clr, otherwise sum of held operands.
    always_ff @(posedge clk) begin
        if (bus.add_clr) add_q <= 8'd0;
        else             add_q <= bus.add_a + bus.add_b;
    end
    assign bus.add_sum   = add_q;
    assign bus_m.add_sum = bus_m.add_a + bus_m.add_b;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_mult(input logic [7:0] a, input logic [7:0] b, output int lat,
                           output logic [15:0] prod, output int busy_low, output int clr_cnt);
        logic seen;
        seen = 1'b0;
        lat = 0; busy_low = 0; clr_cnt = 0;
        bus.multiplier = a;
        bus.multiplicand_in = b;
        bus.start = 1'b1;
        while (!seen && lat < 300) begin
            step();
            lat++;
            if (bus.busy) bus.start = 1'b0;
            else busy_low++;
            if (bus.add_clr) clr_cnt++;
            if (bus.done) seen = 1'b1;
        end
        bus.start = 1'b0;
        prod = bus.product;
        if (!seen) lat = -1;
    endtask

    task automatic test_reset();
        res = 1'b1; res_m = 1'b1;
        bus.start = 1'b0; bus.multiplier = 8'd0; bus.multiplicand_in = 8'd0;
        bus_m.start = 1'b0; bus_m.multiplier = 8'd0; bus_m.multiplicand_in = 8'd0;
        repeat (3) step();
        vectors++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        vectors++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        vectors++; if (bus.product !== 16'd0) begin errors++; $display("FAIL reset_product: got %0d expected 0", bus.product); end
        vectors++; if (bus.add_a !== 8'd0) begin errors++; $display("FAIL reset_add_a: got %0d expected 0", bus.add_a); end
        vectors++; if (bus.add_b !== 8'd0) begin errors++; $display("FAIL reset_add_b: got %0d expected 0", bus.add_b); end
        vectors++; if (bus.add_clr !== 1'b1) begin errors++; $display("FAIL reset_add_clr: got %b expected 1", bus.add_clr); end
        res = 1'b0; res_m = 1'b0;
        step();
        vectors++; if (bus.add_clr !== 1'b0) begin errors++; $display("FAIL idle_add_clr: got %b expected 0", bus.add_clr); end
    endtask

    task automatic test_basic();
        int lat, bl, cc;
        logic [15:0] p;
        do_mult(8'd13, 8'd11, lat, p, bl, cc);
        vectors++; if (lat !== LAT_13) begin errors++; $display("FAIL basic_latency: got %0d expected %0d", lat, LAT_13); end
        vectors++; if (p !== 16'd143) begin errors++; $display("FAIL basic_product: got %0d expected 143", p); end
        vectors++; if (bl !== 0) begin errors++; $display("FAIL basic_busy_gap: got %0d expected 0", bl); end
        vectors++; if (cc !== CLR_13) begin errors++; $display("FAIL basic_clr_count: got %0d expected %0d", cc, CLR_13); end
        step();
        vectors++; if (bus.done !== 1'b0) begin errors++; $display("FAIL done_pulse_width: got %b expected 0", bus.done); end
        vectors++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL busy_after_done: got %b expected 0", bus.busy); end
        repeat (4) step();
        vectors++; if (bus.product !== 16'd143) begin errors++; $display("FAIL product_hold: got %0d expected 143", bus.product); end
    endtask

    task automatic test_max_carry();
        int lat, bl, cc;
        logic [15:0] p;
        do_mult(8'd255, 8'd255, lat, p, bl, cc);
        vectors++; if (lat !== LAT_255) begin errors++; $display("FAIL max_latency: got %0d expected %0d", lat, LAT_255); end
        vectors++; if (p !== 16'hFE01) begin errors++; $display("FAIL max_product: got %h expected fe01", p); end
        step();
    endtask

    task automatic test_zero_skip();
        int lat, bl, cc;
        logic [15:0] p;
        do_mult(8'd0, 8'd200, lat, p, bl, cc);
        vectors++; if (lat !== LAT_0) begin errors++; $display("FAIL zero_latency: got %0d expected %0d", lat, LAT_0); end
        vectors++; if (p !== 16'd0) begin errors++; $display("FAIL zero_product: got %0d expected 0", p); end
        vectors++; if (cc !== CLR_0) begin errors++; $display("FAIL zero_clr_count: got %0d expected %0d", cc, CLR_0); end
        step();
    endtask

    task automatic test_back_to_back();
        int n, lat, bl, cc;
        logic seen;
        logic [15:0] p;
        n = 0; seen = 1'b0;
        bus.multiplier = 8'd13; bus.multiplicand_in = 8'd11; bus.start = 1'b1;
        while (!seen && n < 300) begin
            step();
            n++;
            if (n == 1 || n == 6 || n == 41) bus.start = 1'b0;
            if (n == 5)  begin bus.start = 1'b1; bus.multiplier = 8'd99; bus.multiplicand_in = 8'd77; end
            if (n == 40) begin bus.start = 1'b1; bus.multiplier = 8'd3;  bus.multiplicand_in = 8'd250; end
            if (bus.done) seen = 1'b1;
        end
        if (!seen) n = -1;
        vectors++; if (n !== LAT_13) begin errors++; $display("FAIL busy_start_latency: got %0d expected %0d", n, LAT_13); end
        vectors++; if (bus.product !== 16'd143) begin errors++; $display("FAIL busy_start_product: got %0d expected 143", bus.product); end
        // Start raised during the DONE cycle is taken in the following IDLE cycle.
        do_mult(8'd5, 8'd6, lat, p, bl, cc);
        vectors++; if (lat !== LAT_5 + 1) begin errors++; $display("FAIL held_start_latency: got %0d expected %0d", lat, LAT_5 + 1); end
        vectors++; if (p !== 16'd30) begin errors++; $display("FAIL held_start_product: got %0d expected 30", p); end
        vectors++; if (bl !== 1) begin errors++; $display("FAIL held_start_idle_cycles: got %0d expected 1", bl); end
        step();
    endtask

    task automatic test_reset_mid_op();
        int n, dn, lat, bl, cc;
        logic [15:0] p;
        n = 0; dn = 0;
        bus.multiplier = 8'd100; bus.multiplicand_in = 8'd3; bus.start = 1'b1;
        while (n < 30) begin
            step();
            n++;
            bus.start = 1'b0;
            if (bus.done) dn++;
        end
        res = 1'b1;
        step();
        vectors++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", bus.busy); end
        vectors++; if (bus.product !== 16'd0) begin errors++; $display("FAIL midreset_product: got %0d expected 0", bus.product); end
        vectors++; if (bus.add_clr !== 1'b1) begin errors++; $display("FAIL midreset_add_clr: got %b expected 1", bus.add_clr); end
        res = 1'b0;
        repeat (100) begin
            step();
            if (bus.done) dn++;
        end
        vectors++; if (dn !== 0) begin errors++; $display("FAIL midreset_no_done: got %0d pulses expected 0", dn); end
        do_mult(8'd7, 8'd9, lat, p, bl, cc);
        vectors++; if (lat !== LAT_7) begin errors++; $display("FAIL fresh_latency: got %0d expected %0d", lat, LAT_7); end
        vectors++; if (p !== 16'd63) begin errors++; $display("FAIL fresh_product: got %0d expected 63", p); end
        step();
    endtask

    task automatic test_min_latency();
        int n;
        logic seen;
        n = 0; seen = 1'b0;
        bus_m.multiplier = 8'h80; bus_m.multiplicand_in = 8'hFF; bus_m.start = 1'b1;
        while (!seen && n < 300) begin
            step();
            n++;
            bus_m.start = 1'b0;
            if (bus_m.done) seen = 1'b1;
        end
        if (!seen) n = -1;
        vectors++; if (n !== LAT_MIN) begin errors++; $display("FAIL min_latency: got %0d expected %0d", n, LAT_MIN); end
        vectors++; if (bus_m.product !== 16'd32640) begin errors++; $display("FAIL min_product: got %0d expected 32640", bus_m.product); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max_carry();
        test_zero_skip();
        test_back_to_back();
        test_reset_mid_op();
        test_min_latency();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/mult_ctrl.md
# mult_ctrl

Sequencing controller for the 8×8 unsigned shift-and-add multiplier. It owns the accumulator and multiplier shift registers, drives the registered 8-bit `add` datapath one partial product at a time, and waits a fixed number of cycles for its registered carry chain to settle. It offers a start/done handshake to the host and produces a 16-bit product. It sits directly between the host interface and the `add` instance.

## Interface

Parameters:
- `ADD_LAT`, default 8: cycles the adder operands are held before `add_sum` is sampled; legal range 1..15.

Ports:
- `clk` in 1: single clock, all logic on the rising edge.
- `res` in 1: synchronous, active-high reset.
- `start` in 1: request a multiply; sampled only in IDLE.
- `multiplier` in 8: operand A; sampled with `start`.
- `multiplicand_in` in 8: operand B; sampled with `start`.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse, product valid.
- `product` out 16: result; holds until the next completion.
- `add_a` out 8: to adder `result_in`; equals accumulator high byte.
- `add_b` out 8: to adder `multiplicand`.
- `add_clr` out 1: to adder `res`; equals `res` OR (state==EVAL).
- `add_sum` in 8: from adder `result`.

## Operation

- Registers:
  - `acc_hi[7:0]`: accumulator high byte.
  - `acc_lo[7:0]`: multiplier / product low byte.
  - `mcand[7:0]`: latched multiplicand.
  - `bitcnt[2:0]`: partial-product counter.
  - `wait_cnt[3:0]`: adder settle counter.
  - `cy`: carry into the shift.
- States: IDLE, EVAL, ADD, SHIFT, DONE.
- **IDLE**
  - `start`=1: load `acc_hi`=0, `acc_lo`=`multiplier`, `mcand`=`multiplicand_in`, `bitcnt`=0; go to EVAL.
  - `start`=0: stay.
- **EVAL** (1 cycle)
  - Asserts `add_clr`.
  - `acc_lo[0]`=1: go to ADD with `wait_cnt`=`ADD_LAT`-1.
  - `acc_lo[0]`=0: see Configuration.
- **ADD** (`ADD_LAT` cycles)
  - `add_a`=`acc_hi`; `add_b`=`mcand` when `acc_lo[0]`=1, else 0. Both are stable for the whole state.
  - `wait_cnt` decrements each cycle.
  - When `wait_cnt`=0: capture `acc_hi`=`add_sum` and `cy`=(`add_sum` < `add_a`) as an unsigned compare. The adder has no carry-out, so carry is derived this way. Go to SHIFT.
- **SHIFT** (1 cycle)
  - {`cy`,`acc_hi`,`acc_lo`} ← {1'b0,`cy`,`acc_hi`,`acc_lo[7:1]`}.
  - `bitcnt`=7: `product`←shifted {`acc_hi`,`acc_lo`}; go to DONE.
  - Otherwise: `bitcnt`++; go to EVAL.
- **DONE** (1 cycle): `done`=1; go to IDLE.
- Outside ADD, `add_a`=`acc_hi` and `add_b`=0.
- `start` while `busy`: ignored, no queuing.
- `start` held high: a new operation is accepted in the first IDLE cycle, which is the cycle after DONE.
- Operand inputs are don't-care except in the cycle `start` is accepted.

## Timing

- Reset values:
  - `busy`=0, `done`=0, `product`=0, `add_a`=0, `add_b`=0.
  - `add_clr`=1 while `res` is high.
  - State IDLE; all internal registers 0.
- Reset mid-operation: abandon the multiply and return to IDLE next edge. `product` is cleared, and no `done` is issued for the abandoned operation.
- Without the macro, latency is fixed. `done` is high in cycle 1+8·(`ADD_LAT`+2) after the accepting edge: 81 cycles at `ADD_LAT`=8. `product` is valid from that cycle on.
- `busy` rises the cycle after acceptance and falls together with `done`.

## Configuration

- Macro: `MULT_CTRL_ZERO_SKIP_EN`.
- **Defined:**
  - EVAL with `acc_lo[0]`=0 goes straight to SHIFT with `cy`=0; ADD and `add_clr` are skipped for that bit.
  - Latency = 1 + 8·2 + (number of ones in `multiplier`)·`ADD_LAT`.
- **Undefined:**
  - Every bit passes through ADD; zero bits add `add_b`=0.
  - Latency is constant.

## Test plan

- **Basic multiply:** `multiplier`=13, `multiplicand_in`=11, `ADD_LAT`=8, macro undefined, ideal registered adder model → `done` in cycle 81; `product`=143; `busy` high cycles 1–81.
- **Maximum carry:** 255×255 → `product`=65025 (0xFE01); `cy` set on every add after the first.
- **Zero skip:** `multiplier`=0, `multiplicand_in`=200.
  - Macro defined → `done` at cycle 17, `product`=0, `add_clr` never pulses after reset.
  - Macro undefined → `done` at cycle 81.
- **Start while busy:** `start` pulsed at cycles 5 and 40 with different operands → ignored; first result unchanged. A `start` the cycle after `done` is accepted.
- **Reset mid-operation:** `res` asserted at cycle 30 of 100×3 → next cycle `busy`=0, `product`=0, no `done` pulse. A fresh 7×9 then yields `product`=63.
- **Minimum latency:** `ADD_LAT`=1, 0x80×0xFF → `done` at cycle 25, `product`=32640.
